// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Function : SPI mode-0 responder, oversampled in clk, one-deep tx holding reg
// Revision : 1.0
// ============================================================================
module spi_target #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;
    assign cs_fall   = ~cs_s2 & cs_s3;

    state_t            state;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [DATA_W-1:0] shift_tx;
    logic [DATA_W-1:0] shift_rx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;

    logic              handshake;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_next;

    assign tx_ready  = ~hold_full;
    assign handshake = tx_valid & ~hold_full;
    // A load only ever sees the registered holding state, so a same-cycle
    // handshake is not bypassed into the shifter.
    assign load_word = hold_full ? hold_data : '0;
    assign rx_next   = {shift_rx[DATA_W-2:0], mosi_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            shift_tx    <= '0;
            shift_rx    <= '0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= ~cs_s2;

            if (handshake) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (cs_rise) begin
                state     <= IDLE;
                miso      <= 1'b0;
                bit_cnt   <= '0;
                word_done <= 1'b0;
                if (bit_cnt != '0) begin
                    frame_abort <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        if (cs_fall) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        shift_tx <= load_word;
                        miso     <= load_word[DATA_W-1];
                        if (hold_full) begin
                            hold_full <= 1'b0;
                        end else begin
                            tx_underrun <= 1'b1;
                        end
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            shift_rx <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt   <= '0;
                                rx_data   <= rx_next;
                                rx_valid  <= 1'b1;
                                word_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (sclk_fall) begin
                            if (word_done) begin
                                shift_tx  <= load_word;
                                miso      <= load_word[DATA_W-1];
                                word_done <= 1'b0;
                                if (hold_full) begin
                                    hold_full <= 1'b0;
                                end else begin
                                    tx_underrun <= 1'b1;
                                end
                            end else begin
                                shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
                                miso     <= shift_tx[DATA_W-2];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Function : directed + randomized frames against a word-level transfer model
// Revision : 1.0
// ============================================================================
module tb_spi_target;

    localparam int DATA_W = 8;
    typedef logic [7:0] bq_t[$];

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       sclk     = 1'b0;
    logic       cs_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
    logic [7:0] rx_data;

    spi_target #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: bytes handed to the target are sent in order, one per word start;
    // a word start with nothing pending sends zero and counts an underrun.
    logic [7:0] stream[$];
    logic [7:0] fq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] last_rx = 8'h00;
    int rx_cnt = 0, ur_cnt = 0, ab_cnt = 0;

    initial begin : feeder
        logic ready_prev;
        ready_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_valid && ready_prev && fq.size() > 0) void'(fq.pop_front());
            if (fq.size() > 0) begin
                tx_valid = 1'b1;
                tx_data  = fq[0];
            end else begin
                tx_valid = 1'b0;
            end
            ready_prev = tx_ready;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() > 0) check_eq("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (tx_underrun) ur_cnt++;
            if (frame_abort) ab_cnt++;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic supply(input logic [7:0] b);
        fq.push_back(b);
        stream.push_back(b);
    endtask

    task automatic do_frame(input bq_t words, input int pbits, input logic [7:0] pword,
                            input bit collide, input logic [7:0] cbyte, input bit do_reset);
        logic [7:0] exp_miso[$];
        logic [7:0] got, data;
        int n, nb, ur0, ab0, rx0, exp_ur;
        n = words.size();
        ur0 = ur_cnt; ab0 = ab_cnt; rx0 = rx_cnt; exp_ur = 0;
        // n full words (+ partial) always start n+1 words: the trailing sclk
        // fall of a complete word starts the next one.
        for (int k = 0; k <= n; k++) begin
            if (stream.size() > 0) exp_miso.push_back(stream.pop_front());
            else begin
                exp_miso.push_back(8'h00);
                exp_ur++;
            end
            if (k == 0 && collide) stream.push_back(cbyte);
        end
        if (!do_reset) begin
            foreach (words[k]) exp_rx.push_back(words[k]);
            if (n > 0) last_rx = words[n-1];
        end

        @(negedge clk);
        cs_n = 1'b0;
        if (collide) begin
            fork
                begin
                    repeat (3) @(posedge clk);
                    #1 fq.push_back(cbyte);
                end
            join_none
        end
        repeat (6) @(negedge clk);
        for (int w = 0; w < n + ((pbits > 0) ? 1 : 0); w++) begin
            nb   = (w < n) ? 8 : pbits;
            data = (w < n) ? words[w] : pword;
            got  = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = data[7-i];
                repeat (4) @(negedge clk);
                sclk = 1'b1;
                got  = {got[6:0], miso};
                if (w == 0 && i == 0) check_eq("busy_active", 32'(busy), 32'd1);
                repeat (4) @(negedge clk);
                sclk = 1'b0;
            end
            if (w < n) check_eq($sformatf("miso_word%0d", w), 32'(got), 32'(exp_miso[w]));
        end

        if (do_reset) begin
            #3 rst_n = 1'b0;
            #1;
            check_eq("rst_miso", 32'(miso), 32'd0);
            check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
            check_eq("rst_rx_data", 32'(rx_data), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
            cs_n = 1'b1;
            mosi = 1'b0;
            fq.delete();
            stream.delete();
            exp_rx.delete();
            tx_valid = 1'b0;
            last_rx  = 8'h00;
            @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (6) @(negedge clk);
            return;
        end

        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("underruns", 32'(ur_cnt - ur0), 32'(exp_ur));
        check_eq("aborts", 32'(ab_cnt - ab0), (pbits > 0) ? 32'd1 : 32'd0);
        check_eq("rx_pulses", 32'(rx_cnt - rx0), 32'(n));
        check_eq("rx_data_held", 32'(rx_data), 32'(last_rx));
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("miso_idle", 32'(miso), 32'd0);
        check_eq("tx_ready_end", 32'(tx_ready), (stream.size() == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin : main
        bq_t w;
        int  ns, p;
        repeat (3) @(negedge clk);
        check_eq("reset_miso", 32'(miso), 32'd0);
        check_eq("reset_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("reset_rx_data", 32'(rx_data), 32'd0);
        check_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_pulses", 32'({tx_underrun, frame_abort}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single word
        supply(8'h3C);
        repeat (4) @(negedge clk);
        check_eq("preload_tx_ready", 32'(tx_ready), 32'd0);
        w.delete(); w.push_back(8'hA5);
        do_frame(w, 0, 8'h00, 1'b0, 8'h00, 1'b0);

        // burst under one chip select
        supply(8'h11); supply(8'h22); supply(8'h33);
        repeat (4) @(negedge clk);
        w.delete(); w.push_back(8'hC3); w.push_back(8'h5A); w.push_back(8'hA5);
        do_frame(w, 0, 8'h00, 1'b0, 8'h00, 1'b0);

        // underrun
        w.delete(); w.push_back(8'hFF);
        do_frame(w, 0, 8'h00, 1'b0, 8'h00, 1'b0);

        // abort after 5 bits, then a clean frame
        w.delete();
        do_frame(w, 5, 8'h5A, 1'b0, 8'h00, 1'b0);
        w.delete(); w.push_back(8'h3C);
        do_frame(w, 0, 8'h00, 1'b0, 8'h00, 1'b0);

        // async reset after 3 bits, then a clean frame
        supply(8'h77);
        repeat (4) @(negedge clk);
        w.delete();
        do_frame(w, 3, 8'hA5, 1'b0, 8'h00, 1'b1);
        w.delete(); w.push_back(8'hA5);
        do_frame(w, 0, 8'h00, 1'b0, 8'h00, 1'b0);

        // handshake in the LOAD cycle with holding empty
        w.delete(); w.push_back(8'h12); w.push_back(8'h34);
        do_frame(w, 0, 8'h00, 1'b1, 8'h9E, 1'b0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            ns = $urandom_range(0, 4);
            for (int k = 0; k < ns; k++) supply(8'($urandom));
            repeat (4) @(negedge clk);
            w.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) w.push_back(8'($urandom));
            p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            do_frame(w, p, 8'($urandom), 1'b0, 8'h00, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
